// File: rtl/bpsk_tx_framer.sv
// ---------------------------------------------------------------------------
// bpsk_tx_framer
//
// Purpose:
//   Transmit-side framer that feeds the bpsk_modem. Payload bytes arrive on a
//   valid/ready stream into a one-byte holding buffer. Each frame goes out
//   serially as an alternating 1,0,1,... preamble, the fixed sync word and
//   then the payload bytes, all MSB first. A free-running symbol timer
//   produces the symbol strobe so modem timing never drifts, framed or not.
//
// Parameters:
//   SYMBOL_CLKS    clocks per symbol (>= 2)
//   PREAMBLE_BITS  preamble length in symbols (>= 1)
//   SYNC_WORD      8-bit sync word, sent MSB first
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous reset, active low
//   i_s_data        payload byte
//   i_s_valid       i_s_data / i_s_last are valid
//   i_s_last        byte is the final byte of its frame
//   o_s_ready       holding buffer is empty (low while in reset)
//   o_bit_out       serial symbol value, to modem bit_in
//   o_symbol_tick   one-cycle strobe in the last clock of every symbol
//   o_busy          a frame is in progress
//   o_frame_done    one-cycle pulse after a frame ends normally
//   o_underrun      one-cycle pulse after a frame is aborted for lack of data
// ---------------------------------------------------------------------------
module bpsk_tx_framer #(
  parameter int unsigned SYMBOL_CLKS   = 64,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [7:0]  SYNC_WORD     = 8'hD3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  input  logic       i_s_last,
  output logic       o_s_ready,
  output logic       o_bit_out,
  output logic       o_symbol_tick,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_underrun
);

  localparam int unsigned SYM_W   = $clog2(SYMBOL_CLKS);
  // The bit counter covers both the preamble and the 8-bit sync/byte phases.
  localparam int unsigned CNT_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYMBOL_CLKS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD
  } FramerState;

  FramerState       r_state;
  FramerState       w_nextState;

  logic [SYM_W-1:0] r_symCnt;
  logic             w_symbolTick;

  logic [7:0]       r_bufData;
  logic             r_bufLast;
  logic             r_bufFull;
  logic             w_sReady;
  logic             w_accept;
  logic             w_load;

  // r_shift holds the bits still to be sent after the one on r_bitOut.
  logic [7:0]       r_shift;
  logic [7:0]       w_nextShift;
  logic             r_curLast;
  logic             w_nextCurLast;
  logic [CNT_W-1:0] r_bitCnt;
  logic [CNT_W-1:0] w_nextBitCnt;
  logic             r_bitOut;
  logic             w_nextBitOut;
  logic             r_frameDone;
  logic             w_nextFrameDone;
  logic             r_underrun;
  logic             w_nextUnderrun;

  // Free-running symbol timer; the tick is decoded from the counter register
  // so it is clean and independent of frame activity.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_symCnt <= '0;
    end else if (r_symCnt == SYM_LAST) begin
      r_symCnt <= '0;
    end else begin
      r_symCnt <= r_symCnt + SYM_W'(1);
    end
  end

  assign w_symbolTick = (r_symCnt == SYM_LAST);

  // Ready is held low during reset so nothing is accepted into a buffer
  // that is being cleared.
  assign w_sReady = i_rst & ~r_bufFull;
  assign w_accept = i_s_valid & w_sReady;

  // Holding buffer. Accept needs the buffer empty and load needs it full,
  // so the two never happen on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_bufFull <= 1'b0;
      r_bufData <= '0;
      r_bufLast <= 1'b0;
    end else if (w_accept) begin
      r_bufFull <= 1'b1;
      r_bufData <= i_s_data;
      r_bufLast <= i_s_last;
    end else if (w_load) begin
      r_bufFull <= 1'b0;
    end
  end

  // FSM state and serializer registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_curLast   <= 1'b0;
      r_bitCnt    <= '0;
      r_bitOut    <= 1'b0;
      r_frameDone <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_shift     <= w_nextShift;
      r_curLast   <= w_nextCurLast;
      r_bitCnt    <= w_nextBitCnt;
      r_bitOut    <= w_nextBitOut;
      r_frameDone <= w_nextFrameDone;
      r_underrun  <= w_nextUnderrun;
    end
  end

  // Next-state logic. Nothing moves except on a tick edge, so the symbol on
  // r_bitOut is held for a full symbol period. The end-of-byte decisions use
  // the registered buffer flag, so a byte accepted on that same edge is late.
  always_comb begin
    w_nextState     = r_state;
    w_nextShift     = r_shift;
    w_nextCurLast   = r_curLast;
    w_nextBitCnt    = r_bitCnt;
    w_nextBitOut    = r_bitOut;
    w_nextFrameDone = 1'b0;
    w_nextUnderrun  = 1'b0;
    w_load          = 1'b0;

    if (w_symbolTick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_bufFull) begin
            w_nextState  = ST_PREAMBLE;
            w_nextBitOut = 1'b1;
            w_nextBitCnt = '0;
          end
        end

        ST_PREAMBLE: begin
          if (r_bitCnt == PRE_LAST) begin
            w_nextState  = ST_SYNC;
            w_nextBitOut = SYNC_WORD[7];
            w_nextShift  = {SYNC_WORD[6:0], 1'b0};
            w_nextBitCnt = '0;
          end else begin
            w_nextBitOut = ~r_bitOut;
            w_nextBitCnt = r_bitCnt + CNT_W'(1);
          end
        end

        ST_SYNC: begin
          // The frame only starts with a byte buffered, so it is safe to
          // load unconditionally here.
          if (r_bitCnt == BYTE_LAST) begin
            w_load        = 1'b1;
            w_nextState   = ST_PAYLOAD;
            w_nextBitOut  = r_bufData[7];
            w_nextShift   = {r_bufData[6:0], 1'b0};
            w_nextCurLast = r_bufLast;
            w_nextBitCnt  = '0;
          end else begin
            w_nextBitOut = r_shift[7];
            w_nextShift  = {r_shift[6:0], 1'b0};
            w_nextBitCnt = r_bitCnt + CNT_W'(1);
          end
        end

        ST_PAYLOAD: begin
          if (r_bitCnt == BYTE_LAST) begin
            if (r_curLast) begin
              w_nextState     = ST_IDLE;
              w_nextBitOut    = 1'b0;
              w_nextFrameDone = 1'b1;
            end else if (r_bufFull) begin
              // Next byte follows with no gap symbol.
              w_load        = 1'b1;
              w_nextBitOut  = r_bufData[7];
              w_nextShift   = {r_bufData[6:0], 1'b0};
              w_nextCurLast = r_bufLast;
              w_nextBitCnt  = '0;
            end else begin
              w_nextState    = ST_IDLE;
              w_nextBitOut   = 1'b0;
              w_nextUnderrun = 1'b1;
            end
          end else begin
            w_nextBitOut = r_shift[7];
            w_nextShift  = {r_shift[6:0], 1'b0};
            w_nextBitCnt = r_bitCnt + CNT_W'(1);
          end
        end

        default: begin
          w_nextState  = ST_IDLE;
          w_nextBitOut = 1'b0;
        end
      endcase
    end
  end

  assign o_s_ready     = w_sReady;
  assign o_bit_out     = r_bitOut;
  assign o_symbol_tick = w_symbolTick;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_frame_done  = r_frameDone;
  assign o_underrun    = r_underrun;

endmodule
